vram_bus_master: RTL and testbench

VRAM_BUS_MASTER -- requirements
Module: vram_bus_master

---
 rtl/vram_bus_master_pkg.sv | 15 +
 rtl/vbm_slot_timer.sv | 26 ++
 rtl/vram_bus_master.sv | 139 +++++++++++++
 tb/tb_vram_bus_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_bus_master_pkg.sv
// rtl/vram_bus_master_pkg.sv - shared graphics types and constants for the VRAM bus master
package vram_bus_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SLOT,
    ACCESS,
    ACK,
    ERR
  } vbm_state_e;

  localparam logic [1:0] CPU_SLOT          = 2'b11;
  localparam int         DEF_SLOT_TIMEOUT  = 64;

endpackage

// File: rtl/vbm_slot_timer.sv
// rtl/vbm_slot_timer.sv - 7-bit wait counter that flags expiry after TIMEOUT cycles of waiting
module vbm_slot_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [6:0] LAST = 7'(TIMEOUT - 1);

  logic [6:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 7'd1;
    end
  end

  assign expire = en && (count == LAST);

endmodule

// File: rtl/vram_bus_master.sv
// rtl/vram_bus_master.sv - CPU-to-VRAM bus master that waits for the CPU slot and runs one access
module vram_bus_master
  import vram_bus_master_pkg::*;
#(
  parameter int SLOT_TIMEOUT = DEF_SLOT_TIMEOUT,
  parameter int ADDR_W       = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  input  logic [2:0]        VRAC,
  input  logic [15:0]       vram_rdata,
  output logic [15:0]       MA,
  output logic [15:0]       VBD_wr,
  output logic              VRAMRD_b,
  output logic              VRAMWR,
  output logic              BR_W_b,
  output logic              VBUS_b,
  output logic [15:0]       cpu_rdata,
  output logic              DTACK_b,
  output logic              BERR_b
);

  vbm_state_e        state, state_nx;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              captured;
  logic              expire;

  logic [15:0] ma_nx, vbd_nx;
  logic        rd_b_nx, wr_nx, brw_nx, vbus_nx, dtack_nx, berr_nx;

  vbm_slot_timer #(
    .TIMEOUT (SLOT_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state != WAIT_SLOT),
    .en     (state == WAIT_SLOT),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (cpu_req) state_nx = WAIT_SLOT;
      // Only the 011 code starts a slot; 111 is the second half of one already running.
      WAIT_SLOT: begin
        if (!cpu_req)                       state_nx = IDLE;
        else if (VRAC == {1'b0, CPU_SLOT})  state_nx = ACCESS;
        else if (expire)                    state_nx = ERR;
      end
      ACCESS:    if (VRAC[1:0] != CPU_SLOT) state_nx = cpu_req ? ACK : IDLE;
      ACK:       if (!cpu_req) state_nx = IDLE;
      ERR:       if (!cpu_req) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Pins are decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    ma_nx    = '0;
    vbd_nx   = '0;
    rd_b_nx  = 1'b1;
    wr_nx    = 1'b0;
    brw_nx   = 1'b1;
    vbus_nx  = 1'b1;
    dtack_nx = (state_nx != ACK);
    berr_nx  = (state_nx != ERR);
    if (state_nx == ACCESS) begin
      ma_nx   = 16'({addr_q, 1'b0});
      vbd_nx  = rw_q ? 16'h0000 : wdata_q;
      rd_b_nx = ~rw_q;
      wr_nx   = ~rw_q;
      brw_nx  = rw_q;
      vbus_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MA       <= '0;
      VBD_wr   <= '0;
      VRAMRD_b <= 1'b1;
      VRAMWR   <= 1'b0;
      BR_W_b   <= 1'b1;
      VBUS_b   <= 1'b1;
      DTACK_b  <= 1'b1;
      BERR_b   <= 1'b1;
    end else begin
      MA       <= ma_nx;
      VBD_wr   <= vbd_nx;
      VRAMRD_b <= rd_b_nx;
      VRAMWR   <= wr_nx;
      BR_W_b   <= brw_nx;
      VBUS_b   <= vbus_nx;
      DTACK_b  <= dtack_nx;
      BERR_b   <= berr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rw_q    <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && cpu_req) begin
      rw_q    <= cpu_rw;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
  end

  // Read data is taken once per slot, on the first strobe-phase cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_rdata <= '0;
      captured  <= 1'b0;
    end else if (state != ACCESS) begin
      captured  <= 1'b0;
    end else if (rw_q && VRAC[2] && !captured) begin
      cpu_rdata <= vram_rdata;
      captured  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vram_bus_master.sv
// tb/tb_vram_bus_master.sv - directed self-checking bench for vram_bus_master
module tb_vram_bus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_rw;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic [2:0]  VRAC;
  logic [15:0] vram_rdata;
  logic [15:0] MA;
  logic [15:0] VBD_wr;
  logic        VRAMRD_b;
  logic        VRAMWR;
  logic        BR_W_b;
  logic        VBUS_b;
  logic [15:0] cpu_rdata;
  logic        DTACK_b;
  logic        BERR_b;

  int errors = 0;
  int checks = 0;

  vram_bus_master #(
    .SLOT_TIMEOUT (64),
    .ADDR_W       (13)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_rw     (cpu_rw),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .VRAC       (VRAC),
    .vram_rdata (vram_rdata),
    .MA         (MA),
    .VBD_wr     (VBD_wr),
    .VRAMRD_b   (VRAMRD_b),
    .VRAMWR     (VRAMWR),
    .BR_W_b     (BR_W_b),
    .VBUS_b     (VBUS_b),
    .cpu_rdata  (cpu_rdata),
    .DTACK_b    (DTACK_b),
    .BERR_b     (BERR_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic rw, input logic [12:0] addr, input logic [15:0] wdata);
    cpu_req   = 1'b1;
    cpu_rw    = rw;
    cpu_addr  = addr;
    cpu_wdata = wdata;
  endtask

  int  n;
  logic strobe_seen;

  initial begin
    rst        = 1'b1;
    cpu_req    = 1'b0;
    cpu_rw     = 1'b1;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    VRAC       = 3'b000;
    vram_rdata = '0;
    tick();
    tick();
    check("rst_MA",       MA,                 16'h0000);
    check("rst_VBD_wr",   VBD_wr,             16'h0000);
    check("rst_VRAMRD_b", 16'(VRAMRD_b),      16'h0001);
    check("rst_VRAMWR",   16'(VRAMWR),        16'h0000);
    check("rst_BR_W_b",   16'(BR_W_b),        16'h0001);
    check("rst_VBUS_b",   16'(VBUS_b),        16'h0001);
    check("rst_rdata",    cpu_rdata,          16'h0000);
    check("rst_DTACK_b",  16'(DTACK_b),       16'h0001);
    check("rst_BERR_b",   16'(BERR_b),        16'h0001);
    rst = 1'b0;
    tick();

    // Write 0x1234 to 0x0A5, slot arrives 5 cycles after the request.
    request(1'b0, 13'h00A5, 16'h1234);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wr_wait_VRAMWR", 16'(VRAMWR), 16'h0000);
    end
    VRAC = 3'b011;
    tick();
    check("wr_acc_VRAMWR",   16'(VRAMWR),   16'h0001);
    check("wr_acc_MA",       MA,            16'h014A);
    check("wr_acc_VBD",      VBD_wr,        16'h1234);
    check("wr_acc_VBUS_b",   16'(VBUS_b),   16'h0000);
    check("wr_acc_BR_W_b",   16'(BR_W_b),   16'h0000);
    check("wr_acc_VRAMRD_b", 16'(VRAMRD_b), 16'h0001);
    VRAC = 3'b111;
    tick();
    check("wr_acc2_VRAMWR",  16'(VRAMWR),   16'h0001);
    check("wr_acc2_MA",      MA,            16'h014A);
    VRAC = 3'b000;
    tick();
    check("wr_ack_DTACK_b",  16'(DTACK_b),  16'h0000);
    check("wr_ack_VRAMWR",   16'(VRAMWR),   16'h0000);
    check("wr_ack_MA",       MA,            16'h0000);
    check("wr_ack_VBD",      VBD_wr,        16'h0000);
    cpu_req = 1'b0;
    tick();
    check("wr_done_DTACK_b", 16'(DTACK_b),  16'h0001);
    tick();

    // Read from the top word address; only the first strobe-phase sample is kept.
    request(1'b1, 13'h1FFF, 16'h0000);
    tick();
    VRAC = 3'b011;
    tick();
    check("rd_acc_VRAMRD_b", 16'(VRAMRD_b), 16'h0000);
    check("rd_acc_VRAMWR",   16'(VRAMWR),   16'h0000);
    check("rd_acc_BR_W_b",   16'(BR_W_b),   16'h0001);
    check("rd_acc_MA",       MA,            16'h3FFE);
    check("rd_acc_VBD",      VBD_wr,        16'h0000);
    VRAC = 3'b111;
    vram_rdata = 16'hBEEF;
    tick();
    check("rd_capture",      cpu_rdata,     16'hBEEF);
    check("rd_acc2_VRAMWR",  16'(VRAMWR),   16'h0000);
    vram_rdata = 16'h5555;
    tick();
    check("rd_first_only",   cpu_rdata,     16'hBEEF);
    VRAC = 3'b000;
    tick();
    check("rd_ack_DTACK_b",  16'(DTACK_b),  16'h0000);
    check("rd_ack_VRAMRD_b", 16'(VRAMRD_b), 16'h0001);
    check("rd_ack_VRAMWR",   16'(VRAMWR),   16'h0000);
    cpu_req = 1'b0;
    tick();
    check("rd_done_DTACK_b", 16'(DTACK_b),  16'h0001);
    check("rd_hold",         cpu_rdata,     16'hBEEF);
    tick();

    // Slot timeout: no CPU slot ever arrives.
    request(1'b0, 13'h0010, 16'hCAFE);
    VRAC = 3'b000;
    strobe_seen = 1'b0;
    tick();
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (VRAMWR || !VRAMRD_b || !VBUS_b) strobe_seen = 1'b1;
      if (!BERR_b) break;
    end
    check("to_cycles",      16'(n),            16'd64);
    check("to_BERR_b",      16'(BERR_b),       16'h0000);
    check("to_no_strobe",   16'(strobe_seen),  16'h0000);
    check("to_DTACK_b",     16'(DTACK_b),      16'h0001);
    cpu_req = 1'b0;
    tick();
    check("to_clear_BERR_b", 16'(BERR_b),      16'h0001);
    tick();

    // Abort while waiting: a later slot must not start an access.
    request(1'b0, 13'h0020, 16'h1111);
    tick();
    tick();
    tick();
    cpu_req = 1'b0;
    tick();
    VRAC = 3'b011;
    strobe_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (VRAMWR || !VBUS_b) strobe_seen = 1'b1;
      VRAC = (i == 0) ? 3'b111 : 3'b000;
    end
    check("abw_no_strobe",  16'(strobe_seen), 16'h0000);
    check("abw_DTACK_b",    16'(DTACK_b),     16'h0001);

    // Abort inside the access: slot completes, no acknowledge.
    request(1'b0, 13'h0001, 16'hA5A5);
    VRAC = 3'b000;
    tick();
    VRAC = 3'b011;
    tick();
    check("aba_VRAMWR",     16'(VRAMWR),      16'h0001);
    check("aba_MA",         MA,               16'h0002);
    cpu_req = 1'b0;
    VRAC = 3'b111;
    tick();
    check("aba_finish_VRAMWR", 16'(VRAMWR),   16'h0001);
    VRAC = 3'b000;
    tick();
    check("aba_end_VRAMWR", 16'(VRAMWR),      16'h0000);
    check("aba_end_DTACK_b", 16'(DTACK_b),    16'h0001);
    tick();
    check("aba_idle_DTACK_b", 16'(DTACK_b),   16'h0001);

    // Reset in the middle of a write.
    request(1'b0, 13'h00A5, 16'h1234);
    tick();
    VRAC = 3'b011;
    tick();
    check("rstm_VRAMWR_pre", 16'(VRAMWR),     16'h0001);
    rst  = 1'b1;
    VRAC = 3'b111;
    tick();
    check("rstm_VRAMWR",    16'(VRAMWR),      16'h0000);
    check("rstm_VBUS_b",    16'(VBUS_b),      16'h0001);
    check("rstm_MA",        MA,               16'h0000);
    check("rstm_VBD",       VBD_wr,           16'h0000);
    check("rstm_DTACK_b",   16'(DTACK_b),     16'h0001);
    check("rstm_rdata",     cpu_rdata,        16'h0000);
    rst     = 1'b0;
    cpu_req = 1'b0;
    VRAC    = 3'b000;
    tick();
    check("rstm_after_DTACK_b", 16'(DTACK_b), 16'h0001);
    check("rstm_after_VRAMRD_b", 16'(VRAMRD_b), 16'h0001);
    tick();

    // Request arriving mid-slot waits for the next slot start.
    request(1'b0, 13'h0100, 16'h0F0F);
    VRAC = 3'b111;
    tick();
    tick();
    check("mid_111_VBUS_b", 16'(VBUS_b),      16'h0001);
    VRAC = 3'b000;
    tick();
    check("mid_000_VBUS_b", 16'(VBUS_b),      16'h0001);
    VRAC = 3'b011;
    tick();
    check("mid_slot_VBUS_b", 16'(VBUS_b),     16'h0000);
    check("mid_slot_MA",    MA,               16'h0200);
    VRAC = 3'b111;
    tick();
    VRAC = 3'b000;
    tick();
    check("mid_ack_DTACK_b", 16'(DTACK_b),    16'h0000);
    cpu_req = 1'b0;
    tick();
    check("mid_done_DTACK_b", 16'(DTACK_b),   16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
